// File: rtl/pixel_scan_pkg.sv
// -----------------------------------------------------------------------------
// pixel_scan_pkg
// Shared helpers for the raster coordinate generator:
//   clog2_min1      - counter width for a given maximum dimension (at least 1)
//   sanitize_dim    - maps an illegal requested dimension (0 or above max) to max
//   in_halo_band    - true when a coordinate lies within 'halo' of either edge
//                     of a dimension of length 'size'
// -----------------------------------------------------------------------------
package pixel_scan_pkg;

  // Smallest w >= 1 with 2**w >= n.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // A requested frame dimension of 0, or one larger than the hardware limit,
  // falls back to the limit. A dimension of 1 is legal.
  function automatic int sanitize_dim(input int value, input int max_dim);
    return ((value == 0) || (value > max_dim)) ? max_dim : value;
  endfunction

  // Evaluated on 32-bit unsigned operands so that 'size - 1 - halo' never
  // underflows for small frames: pos > size-1-halo is rewritten as
  // pos + halo >= size. A dimension no wider than the full window is border
  // everywhere.
  function automatic logic in_halo_band(input int unsigned pos,
                                        input int unsigned size,
                                        input int unsigned halo);
    return (size <= 2 * halo) || (pos < halo) || (pos + halo >= size);
  endfunction

endpackage

// File: rtl/mod_counter_rt.sv
// -----------------------------------------------------------------------------
// mod_counter_rt
// Counter with a runtime modulus: counts 0 .. modulus-1 on enable, then wraps.
// Ports:
//   clk       - system clock
//   reset_n   - asynchronous active-low reset (count = 0)
//   enable    - advance one step this cycle
//   clear     - synchronous return to 0, takes priority over enable
//   modulus   - wrap length, one bit wider than count so 2**WIDTH is
//               representable; must be >= 1
//   count     - current value
//   max_tick  - count == modulus-1 (combinational from the register)
// -----------------------------------------------------------------------------
module mod_counter_rt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH:0]   modulus,
  output logic [WIDTH-1:0] count,
  output logic             max_tick
);

  // A modulus of 1 makes max_tick permanently high, so the counter stays at 0
  // and wraps on every enabled step.
  assign max_tick = ({1'b0, count} == (modulus - (WIDTH + 1)'(1)));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= max_tick ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pixel_coord_scanner.sv
// -----------------------------------------------------------------------------
// pixel_coord_scanner
// Two-dimensional raster coordinate generator for the spatial-filter datapath.
// A column counter and a row counter (advanced by the column wrap) walk a frame
// whose size is taken from a shadow copy of cfg_cols/cfg_rows. The shadow copy
// only reloads on clear or on the enabled frame-wrap cycle, so a frame never
// changes size part-way through.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   enable        - pixel-valid strobe: advance one pixel
//   clear         - synchronous restart at (0,0) with config reload
//   cfg_cols/rows - requested frame size (0 or above max selects the max)
//   col, row      - coordinate of the pixel accepted this cycle
//   first_pixel   - (0,0)
//   line_end      - last column of the line
//   frame_end     - last pixel of the frame
//   border        - pixel within HALO of any frame edge
//   frame_done    - registered one-cycle pulse after a frame wrap
//   frame_cnt     - completed frames, wrapping
// All outputs derive from registers only.
// -----------------------------------------------------------------------------
module pixel_coord_scanner
  import pixel_scan_pkg::*;
#(
  parameter  int MAX_COLS   = 640,
  parameter  int MAX_ROWS   = 480,
  parameter  int HALO       = 1,
  parameter  int FRAME_BITS = 8,
  localparam int COL_BITS   = clog2_min1(MAX_COLS),
  localparam int ROW_BITS   = clog2_min1(MAX_ROWS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [COL_BITS-1:0]   cfg_cols,
  input  logic [ROW_BITS-1:0]   cfg_rows,
  output logic [COL_BITS-1:0]   col,
  output logic [ROW_BITS-1:0]   row,
  output logic                  first_pixel,
  output logic                  line_end,
  output logic                  frame_end,
  output logic                  border,
  output logic                  frame_done,
  output logic [FRAME_BITS-1:0] frame_cnt
);

  // Shadow dimensions are one bit wider than the coordinates so a
  // power-of-two maximum is still representable.
  localparam logic [COL_BITS:0] MAX_COLS_Q = (COL_BITS + 1)'(MAX_COLS);
  localparam logic [ROW_BITS:0] MAX_ROWS_Q = (ROW_BITS + 1)'(MAX_ROWS);

  logic [COL_BITS:0] cols_q;
  logic [ROW_BITS:0] rows_q;
  logic [COL_BITS:0] cols_load;
  logic [ROW_BITS:0] rows_load;
  logic              col_tick;
  logic              row_tick;
  logic              frame_wrap;

  assign cols_load = (COL_BITS + 1)'(sanitize_dim(32'(cfg_cols), MAX_COLS));
  assign rows_load = (ROW_BITS + 1)'(sanitize_dim(32'(cfg_rows), MAX_ROWS));

  // Clear outranks enable; the counters apply the same priority internally.
  assign frame_wrap = enable && frame_end && !clear;

  mod_counter_rt #(.WIDTH(COL_BITS)) u_col_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .clear    (clear),
    .modulus  (cols_q),
    .count    (col),
    .max_tick (col_tick)
  );

  mod_counter_rt #(.WIDTH(ROW_BITS)) u_row_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable && col_tick),
    .clear    (clear),
    .modulus  (rows_q),
    .count    (row),
    .max_tick (row_tick)
  );

  assign first_pixel = (col == '0) && (row == '0);
  assign line_end    = col_tick;
  assign frame_end   = col_tick && row_tick;
  assign border      = in_halo_band(32'(col), 32'(cols_q), HALO) ||
                       in_halo_band(32'(row), 32'(rows_q), HALO);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cols_q     <= MAX_COLS_Q;
      rows_q     <= MAX_ROWS_Q;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else if (clear) begin
      cols_q     <= cols_load;
      rows_q     <= rows_load;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_wrap;
      if (frame_wrap) begin
        cols_q    <= cols_load;
        rows_q    <= rows_load;
        frame_cnt <= frame_cnt + FRAME_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_pixel_coord_scanner.sv
// -----------------------------------------------------------------------------
// tb_pixel_coord_scanner
// Self-checking bench: a directed 4x3 vector table, hand-written corner-case
// sequences and randomized stimulus, all compared against an integer raster
// model of the scanner.
// -----------------------------------------------------------------------------
module tb_pixel_coord_scanner;

  localparam int MAX_COLS   = 640;
  localparam int MAX_ROWS   = 480;
  localparam int HALO       = 1;
  localparam int FRAME_BITS = 8;
  localparam int COL_BITS   = $clog2(MAX_COLS);
  localparam int ROW_BITS   = $clog2(MAX_ROWS);

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  enable;
  logic                  clear;
  logic [COL_BITS-1:0]   cfg_cols;
  logic [ROW_BITS-1:0]   cfg_rows;
  logic [COL_BITS-1:0]   col;
  logic [ROW_BITS-1:0]   row;
  logic                  first_pixel;
  logic                  line_end;
  logic                  frame_end;
  logic                  border;
  logic                  frame_done;
  logic [FRAME_BITS-1:0] frame_cnt;

  pixel_coord_scanner #(
    .MAX_COLS   (MAX_COLS),
    .MAX_ROWS   (MAX_ROWS),
    .HALO       (HALO),
    .FRAME_BITS (FRAME_BITS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .clear       (clear),
    .cfg_cols    (cfg_cols),
    .cfg_rows    (cfg_rows),
    .col         (col),
    .row         (row),
    .first_pixel (first_pixel),
    .line_end    (line_end),
    .frame_end   (frame_end),
    .border      (border),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model (plain integers) ----------------
  int m_col, m_row, m_cols, m_rows, m_cnt;
  int m_done;

  function automatic int san(input int v, input int mx);
    if (v == 0 || v > mx) return mx;
    return v;
  endfunction

  task automatic model_reset();
    m_col  = 0;
    m_row  = 0;
    m_cols = MAX_COLS;
    m_rows = MAX_ROWS;
    m_cnt  = 0;
    m_done = 0;
  endtask

  // One rising edge worth of behaviour, using the inputs held across the edge.
  task automatic model_step();
    if (clear) begin
      m_col  = 0;
      m_row  = 0;
      m_cols = san(int'(cfg_cols), MAX_COLS);
      m_rows = san(int'(cfg_rows), MAX_ROWS);
      m_done = 0;
    end else if (enable) begin
      m_done = (m_col == m_cols - 1 && m_row == m_rows - 1) ? 1 : 0;
      if (m_col < m_cols - 1) begin
        m_col = m_col + 1;
      end else begin
        m_col = 0;
        if (m_row < m_rows - 1) begin
          m_row = m_row + 1;
        end else begin
          m_row  = 0;
          m_cnt  = (m_cnt + 1) % (1 << FRAME_BITS);
          m_cols = san(int'(cfg_cols), MAX_COLS);
          m_rows = san(int'(cfg_rows), MAX_ROWS);
        end
      end
    end else begin
      m_done = 0;
    end
  endtask

  function automatic int exp_border();
    if (m_cols <= 2 * HALO || m_rows <= 2 * HALO) return 1;
    return (m_col < HALO || m_col >= m_cols - HALO ||
            m_row < HALO || m_row >= m_rows - HALO) ? 1 : 0;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic check_model();
    check("col",         int'(col),         m_col);
    check("row",         int'(row),         m_row);
    check("first_pixel", int'(first_pixel), (m_col == 0 && m_row == 0) ? 1 : 0);
    check("line_end",    int'(line_end),    (m_col == m_cols - 1) ? 1 : 0);
    check("frame_end",   int'(frame_end),
          (m_col == m_cols - 1 && m_row == m_rows - 1) ? 1 : 0);
    check("border",      int'(border),      exp_border());
    check("frame_done",  int'(frame_done),  m_done);
    check("frame_cnt",   int'(frame_cnt),   m_cnt);
  endtask

  // Drive inputs, take one clock edge, then compare just after the edge.
  task automatic step(input logic clr, input logic en);
    clear  = clr;
    enable = en;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic set_cfg(input int c, input int r);
    cfg_cols = COL_BITS'(c);
    cfg_rows = ROW_BITS'(r);
  endtask

  // ---------------- directed table: 4x3 frame ----------------
  typedef struct {
    logic clr;
    logic en;
    int   ecol;
    int   erow;
    logic ele;
    logic efe;
    logic ebd;
    logic edone;
    int   ecnt;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int nb;
    int cnt_before;

    tbl[0]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[1]  = '{1'b0, 1'b1, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[2]  = '{1'b0, 1'b1, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[3]  = '{1'b0, 1'b1, 3, 0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    tbl[4]  = '{1'b0, 1'b1, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[5]  = '{1'b0, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[6]  = '{1'b0, 1'b1, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[7]  = '{1'b0, 1'b1, 3, 1, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    tbl[8]  = '{1'b0, 1'b1, 0, 2, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[9]  = '{1'b0, 1'b1, 1, 2, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[10] = '{1'b0, 1'b1, 2, 2, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[11] = '{1'b0, 1'b1, 3, 2, 1'b1, 1'b1, 1'b1, 1'b0, 0};
    tbl[12] = '{1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    tbl[13] = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1};

    // ---- reset state ----
    reset_n = 1'b0;
    enable  = 1'b0;
    clear   = 1'b0;
    set_cfg(4, 3);
    model_reset();
    #12;
    check_model();
    check("rst_first_pixel", int'(first_pixel), 1);
    check("rst_border",      int'(border),      1);
    #1 reset_n = 1'b1;

    // ---- 4x3 table ----
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].clr, tbl[i].en);
      check($sformatf("tbl%0d_col", i),  int'(col),        tbl[i].ecol);
      check($sformatf("tbl%0d_row", i),  int'(row),        tbl[i].erow);
      check($sformatf("tbl%0d_le", i),   int'(line_end),   int'(tbl[i].ele));
      check($sformatf("tbl%0d_fe", i),   int'(frame_end),  int'(tbl[i].efe));
      check($sformatf("tbl%0d_bd", i),   int'(border),     int'(tbl[i].ebd));
      check($sformatf("tbl%0d_done", i), int'(frame_done), int'(tbl[i].edone));
      check($sformatf("tbl%0d_cnt", i),  int'(frame_cnt),  tbl[i].ecnt);
    end

    // ---- config change mid-frame: 4x3 completes, next frame is 6x2 ----
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    check("cfgchg_at_1_1", int'(col) * 100 + int'(row), 101);
    set_cfg(6, 2);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    check("cfgchg_old_frame_end", int'(frame_end), 1);
    check("cfgchg_old_col", int'(col), 3);
    step(1'b0, 1'b1);
    check("cfgchg_wrap_done", int'(frame_done), 1);
    check("cfgchg_wrap_cnt",  int'(frame_cnt),  2);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    check("cfgchg_new_le_col5", int'(line_end) * 10 + int'(col), 15);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    check("cfgchg_new_fe_5_1", int'(frame_end) * 1000 + int'(col) * 10 + int'(row), 1051);
    step(1'b0, 1'b1);
    check("cfgchg_new_wrap", int'(frame_done) * 10 + int'(frame_cnt), 13);

    // ---- border map of a 5x4 frame ----
    set_cfg(5, 4);
    step(1'b1, 1'b0);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (border == 1'b0) nb++;
      step(1'b0, 1'b1);
    end
    check("border_5x4_interior_count", nb, 6);

    // ---- sanitising: 0 cols -> MAX_COLS, MAX_ROWS+5 rows -> MAX_ROWS ----
    set_cfg(0, MAX_ROWS + 5);
    step(1'b1, 1'b0);
    for (int i = 0; i < MAX_COLS - 1; i++) step(1'b0, 1'b1);
    check("sanitize_col",      int'(col),       MAX_COLS - 1);
    check("sanitize_line_end", int'(line_end),  1);
    check("sanitize_frame_end", int'(frame_end), 0);
    step(1'b0, 1'b1);
    check("sanitize_next_row", int'(row), 1);

    // ---- clear with enable at (2,1), then enable gaps ----
    set_cfg(4, 3);
    step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    check("clr_en_at_2_1", int'(col) * 100 + int'(row), 201);
    cnt_before = int'(frame_cnt);
    step(1'b1, 1'b1);
    check("clr_en_col",  int'(col),        0);
    check("clr_en_row",  int'(row),        0);
    check("clr_en_done", int'(frame_done), 0);
    check("clr_en_cnt",  int'(frame_cnt),  cnt_before);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      check("gap_hold_col", int'(col), 2);
    end

    // ---- async reset between clock edges ----
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_model();
    check("async_rst_col", int'(col), 0);
    check("async_rst_row", int'(row), 0);
    #2 reset_n = 1'b1;

    // ---- 256 frames of 1x1: frame_cnt wraps 255 -> 0 ----
    set_cfg(1, 1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b1);
      check("one_px_done", int'(frame_done), 1);
      if (i == 254) check("one_px_cnt_255", int'(frame_cnt), 255);
    end
    check("one_px_cnt_wrap", int'(frame_cnt), 0);

    // ---- randomized stimulus against the model ----
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) set_cfg($urandom_range(0, 9), $urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) set_cfg($urandom_range(MAX_COLS + 1, 1023),
                                               $urandom_range(1, 5));
      step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_coord_scanner.md
Name: pixel_coord_scanner

Overview:
Parametrised two-dimensional raster coordinate generator for the spatial-filter datapath. It replaces the single 1-D modulo counter with chained column and row counters and runtime-programmable frame dimensions. It also produces line/frame boundary flags, a filter-window border flag and a frame counter. It sits beside the pixel input stream and drives line-buffer addressing and the border-handling muxes of the filter.

Parameters:
MAX_COLS, 640, largest supported frame width in pixels (>=2)
MAX_ROWS, 480, largest supported frame height in lines (>=2)
HALO, 1, filter half-window (kernel = 2*HALO+1); pixels within HALO of any edge are border
FRAME_BITS, 8, width of the wrapping frame counter

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  advance one pixel this cycle (pixel-valid strobe)
clear  in  1  synchronous restart at pixel (0,0), reload config
cfg_cols  in  COL_BITS  requested frame width
cfg_rows  in  ROW_BITS  requested frame height
col  out  COL_BITS  current column
row  out  ROW_BITS  current row
first_pixel  out  1  col==0 && row==0
line_end  out  1  col==cols_q-1
frame_end  out  1  line_end && row==rows_q-1
border  out  1  current pixel lies in the HALO band
frame_done  out  1  one-cycle pulse, registered, after frame wrap
frame_cnt  out  FRAME_BITS  completed frames, wraps modulo 2^FRAME_BITS

Behaviour:
- COL_BITS = clog2(MAX_COLS), ROW_BITS = clog2(MAX_ROWS), minimum 1.
- Reset (reset_n low, async): col=0, row=0, frame_cnt=0, frame_done=0, cols_q=MAX_COLS, rows_q=MAX_ROWS. Combinational flags follow: first_pixel=1, line_end=0, frame_end=0, border=1 if HALO>0.
- Shadow config cols_q/rows_q loads from cfg_* only on clear, or on the enabled frame-wrap cycle. A frame never changes size mid-frame.
- Config sanitising at load: a value of 0 or above MAX loads MAX. A value of 1 is legal; that counter then wraps every step.
- Priority: reset_n > clear > enable.
- clear: col=0 and row=0 next cycle, config reloaded, frame_cnt unchanged, frame_done=0. The enable in the same cycle is ignored.
- enable, not line_end: col+1.
- enable, line_end, not frame_end: col=0, row+1.
- enable, frame_end: col=0, row=0, frame_cnt+1 (wraps), frame_done=1 next cycle.
- enable low: all state holds. frame_done drops after one cycle regardless.
- Flags are combinational from registered state (zero latency relative to col/row). The pixel accepted on an enable cycle is the one shown by col/row in that cycle.
- border = col<HALO or col>cols_q-1-HALO or row<HALO or row>rows_q-1-HALO. Evaluate at width+1 bits so small frames cannot underflow. If cols_q or rows_q <= 2*HALO, border=1 everywhere.
- No combinational path from inputs to outputs except through registers.

Decomposition:
- Package pixel_scan_pkg: clog2 function, COL_BITS/ROW_BITS derivation, HALO-band compare function.
- One sub-module mod_counter_rt: a runtime-modulus counter with enable, sync clear, async active-low reset and a max_tick output. It is instantiated twice: column, then row enabled by column max_tick. The top level holds shadow config, flags, frame_done and frame_cnt.

Test Plan:
- Reset release, cfg 4x3, clear then 12 enables: col/row sequence (0,0)..(3,2). line_end high at col=3. frame_end at (3,2). frame_done pulses the cycle after the 12th enable. frame_cnt=1.
- Change cfg to 6x2 at pixel (1,1) of a 4x3 frame: the current frame completes as 4x3, and the next frame wraps at col=5, row=1.
- HALO=1, cfg 5x4: border=0 only at col 1..3 with row 1..2 (6 pixels), 1 at the other 14.
- cfg_cols=0 and cfg_rows=MAX_ROWS+5 loaded by clear: cols_q=MAX_COLS and rows_q=MAX_ROWS. Verify line_end at col=MAX_COLS-1.
- clear and enable asserted together at (2,1): next state (0,0), no frame_done, frame_cnt unchanged. Gaps of enable=0 hold all outputs.
- reset_n asserted mid-frame asynchronously (between clock edges): outputs go to reset values immediately. frame_cnt 255→0 wrap checked with FRAME_BITS=8 over 256 1x1 frames (frame_done every enabled cycle).
